ifu: RTL and testbench

Instruction fetch unit for the multicycle NPC core. It owns the PC, issues one instruction-read request at a time to the memory side over a valid/ready request channel, and captures the returned word. It presents the captured (pc, inst) pair to the decode stage over a valid/ready handshake. It is the stage directly upstream of instruction memory, and it also handles control-flow redirects from execute, including discarding in-flight fetches.

---
 rtl/ifu_if.sv | 32 +++
 rtl/ifu.sv | 120 ++++++++++++
 tb/tb_ifu.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_if.sv
// rtl/ifu_if.sv - fetch unit bundle: memory request/response, decode handshake, redirect
interface ifu_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic                  mem_resp_valid;
  logic [DATA_WIDTH-1:0] mem_resp_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] out_pc;
  logic [DATA_WIDTH-1:0] out_inst;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic [31:0]           fetch_count;

  // fetch unit side
  modport master (
    output mem_req_valid, mem_req_addr, out_valid, out_pc, out_inst, fetch_count,
    input  mem_req_ready, mem_resp_valid, mem_resp_data, out_ready,
           redirect_valid, redirect_pc
  );

  // memory / decode / execute side
  modport slave (
    input  mem_req_valid, mem_req_addr, out_valid, out_pc, out_inst, fetch_count,
    output mem_req_ready, mem_resp_valid, mem_resp_data, out_ready,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ifu.sv
// rtl/ifu.sv - instruction fetch unit: one outstanding fetch, redirect with in-flight discard
module ifu #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
  input logic   clk,
  input logic   rst,
  ifu_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
  logic                  drop_q, drop_d;
  logic [ADDR_WIDTH-1:0] out_pc_q, out_pc_d;
  logic [DATA_WIDTH-1:0] out_inst_q, out_inst_d;
  logic [31:0]           fetch_count_q, fetch_count_d;

  logic [ADDR_WIDTH-1:0] target;
  logic                  req_hs;
  logic                  out_hs;

  assign target = {bus.redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  assign req_hs = (state_q == REQ) && bus.mem_req_ready;
  assign out_hs = (state_q == HOLD) && bus.out_ready;

  assign bus.mem_req_valid = (state_q == REQ);
  assign bus.mem_req_addr  = pc_q;
  assign bus.out_valid     = (state_q == HOLD);
  assign bus.out_pc        = out_pc_q;
  assign bus.out_inst      = out_inst_q;
  assign bus.fetch_count   = fetch_count_q;

  // Next-state logic; a redirect outranks every other event in its cycle
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    drop_d        = drop_q;
    out_pc_d      = out_pc_q;
    out_inst_d    = out_inst_q;
    fetch_count_d = fetch_count_q;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (bus.redirect_valid) pc_d = target;
      end
      REQ: begin
        if (req_hs) begin
          state_d  = WAIT;
          req_pc_d = pc_q;
          drop_d   = bus.redirect_valid;
        end
        if (bus.redirect_valid) pc_d = target;
      end
      WAIT: begin
        if (bus.redirect_valid) begin
          pc_d = target;
          if (bus.mem_resp_valid) begin
            state_d = REQ;
            drop_d  = 1'b0;
          end else begin
            drop_d  = 1'b1;
          end
        end else if (bus.mem_resp_valid) begin
          if (drop_q) begin
            // response belongs to a fetch made stale by an earlier redirect
            state_d = REQ;
            drop_d  = 1'b0;
          end else begin
            state_d    = HOLD;
            out_pc_d   = req_pc_q;
            out_inst_d = bus.mem_resp_data;
          end
        end
      end
      HOLD: begin
        if (bus.redirect_valid) begin
          state_d = REQ;
          pc_d    = target;
        end else if (out_hs) begin
          state_d       = REQ;
          pc_d          = pc_q + ADDR_WIDTH'(4);
          fetch_count_d = fetch_count_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset; reset abandons any outstanding fetch
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      req_pc_q      <= '0;
      drop_q        <= 1'b0;
      out_pc_q      <= '0;
      out_inst_q    <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_pc_q      <= req_pc_d;
      drop_q        <= drop_d;
      out_pc_q      <= out_pc_d;
      out_inst_q    <= out_inst_d;
      fetch_count_q <= fetch_count_d;
    end
  end

endmodule

// File: tb/tb_ifu.sv
// tb/tb_ifu.sv - directed table, hand sequences and randomized run against a transaction model
module tb_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic clk;
  logic rst;

  ifu_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  ifu #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
    logic        ordy;
    logic        redir;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] eaddr;
    logic        eov;
    logic [31:0] eopc;
    logic [31:0] einst;
    logic [31:0] ecnt;
  } vec_t;

  vec_t tbl[20];

  // random-phase model state
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  bit          pend;
  int          timer;
  logic [31:0] raddr;
  int          n_out_hs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rd,
                              input logic ordy, input logic redir, input logic [31:0] rpc,
                              input logic ev, input logic [31:0] eaddr, input logic eov,
                              input logic [31:0] eopc, input logic [31:0] einst,
                              input logic [31:0] ecnt);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rd = rd; v.ordy = ordy; v.redir = redir; v.rpc = rpc;
    v.ev = ev; v.eaddr = eaddr; v.eov = eov; v.eopc = eopc; v.einst = einst; v.ecnt = ecnt;
    return v;
  endfunction

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'd3) ^ 32'h5A00_0013;
  endfunction

  task automatic idle_inputs();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
  endtask

  // leaves time at posedge+1 with rst still high and the DUT in IDLE
  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_req_valid", 32'(bus.mem_req_valid), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_pc", bus.out_pc, 0);
    check("rst_out_inst", bus.out_inst, 0);
    check("rst_fetch_count", bus.fetch_count, 0);
    check("rst_addr", bus.mem_req_addr, RST_PC);
    @(posedge clk); #1;
  endtask

  task automatic rnd_cycle(input bit calm);
    bit req_hs, out_hs, rv;
    bus.mem_req_ready  = calm ? 1'b1 : 1'($urandom % 2);
    bus.out_ready      = calm ? 1'b1 : 1'(($urandom % 4) != 0);
    bus.redirect_valid = calm ? 1'b0 : 1'(($urandom % 12) == 0);
    bus.redirect_pc    = $urandom;
    if (pend && timer == 0) begin
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = memf(raddr);
    end else begin
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_data  = $urandom;
      if (pend) timer--;
    end
    @(negedge clk);
    req_hs = bus.mem_req_valid && bus.mem_req_ready;
    out_hs = bus.out_valid && bus.out_ready;
    rv     = bus.mem_resp_valid;
    check("rnd_fetch_count", bus.fetch_count, m_cnt);
    if (req_hs) begin
      check("rnd_one_outstanding", 32'(pend), 0);
      check("rnd_req_addr", bus.mem_req_addr, m_pc);
      pend  = 1'b1;
      timer = $urandom_range(0, 2);
      raddr = bus.mem_req_addr;
    end else if (rv) begin
      pend = 1'b0;
    end
    if (bus.redirect_valid) begin
      m_pc = {bus.redirect_pc[31:2], 2'b00};
    end else if (out_hs) begin
      check("rnd_out_pc", bus.out_pc, m_pc);
      check("rnd_out_inst", bus.out_inst, memf(m_pc));
      m_pc = m_pc + 32'd4;
      m_cnt = m_cnt + 32'd1;
      n_out_hs++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] a0;
    bit got_req;
    int guard;

    // rdy rv rd ordy redir rpc | ev eaddr eov eopc einst ecnt
    tbl[0]  = mk(1,0,32'h0,1,0,32'h0,          0,32'h8000_0000,0,32'h0,32'h0,0);
    tbl[1]  = mk(1,0,32'h0,1,0,32'h0,          1,32'h8000_0000,0,32'h0,32'h0,0);
    tbl[2]  = mk(1,1,32'h13,1,0,32'h0,         0,32'h8000_0000,0,32'h0,32'h0,0);
    tbl[3]  = mk(1,0,32'h0,1,0,32'h0,          0,32'h8000_0000,1,32'h8000_0000,32'h13,0);
    tbl[4]  = mk(1,0,32'h0,1,0,32'h0,          1,32'h8000_0004,0,32'h8000_0000,32'h13,1);
    tbl[5]  = mk(1,1,32'h13,1,0,32'h0,         0,32'h8000_0004,0,32'h8000_0000,32'h13,1);
    tbl[6]  = mk(1,0,32'h0,1,0,32'h0,          0,32'h8000_0004,1,32'h8000_0004,32'h13,1);
    tbl[7]  = mk(1,0,32'h0,1,0,32'h0,          1,32'h8000_0008,0,32'h8000_0004,32'h13,2);
    tbl[8]  = mk(1,1,32'h13,1,0,32'h0,         0,32'h8000_0008,0,32'h8000_0004,32'h13,2);
    tbl[9]  = mk(1,0,32'h0,1,0,32'h0,          0,32'h8000_0008,1,32'h8000_0008,32'h13,2);
    tbl[10] = mk(1,0,32'h0,1,0,32'h0,          1,32'h8000_000C,0,32'h8000_0008,32'h13,3);
    tbl[11] = mk(1,1,32'h13,1,1,32'h8000_0103, 0,32'h8000_000C,0,32'h8000_0008,32'h13,3);
    tbl[12] = mk(1,0,32'h0,1,0,32'h0,          1,32'h8000_0100,0,32'h8000_0008,32'h13,3);
    tbl[13] = mk(1,1,32'h0010_0093,1,0,32'h0,  0,32'h8000_0100,0,32'h8000_0008,32'h13,3);
    tbl[14] = mk(1,0,32'h0,1,1,32'h8000_0203,  0,32'h8000_0100,1,32'h8000_0100,32'h0010_0093,3);
    tbl[15] = mk(0,0,32'h0,1,0,32'h0,          1,32'h8000_0200,0,32'h8000_0100,32'h0010_0093,3);
    tbl[16] = mk(1,0,32'h0,1,0,32'h0,          1,32'h8000_0200,0,32'h8000_0100,32'h0010_0093,3);
    tbl[17] = mk(1,0,32'h0,1,1,32'h8000_0301,  0,32'h8000_0200,0,32'h8000_0100,32'h0010_0093,3);
    tbl[18] = mk(1,1,32'hFFFF_FFFF,1,0,32'h0,  0,32'h8000_0300,0,32'h8000_0100,32'h0010_0093,3);
    tbl[19] = mk(0,0,32'h0,1,0,32'h0,          1,32'h8000_0300,0,32'h8000_0100,32'h0010_0093,3);

    // directed table: zero-wait streaming, redirects in WAIT and HOLD
    do_reset();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.mem_req_ready  = tbl[i].rdy;
      bus.mem_resp_valid = tbl[i].rv;
      bus.mem_resp_data  = tbl[i].rd;
      bus.out_ready      = tbl[i].ordy;
      bus.redirect_valid = tbl[i].redir;
      bus.redirect_pc    = tbl[i].rpc;
      @(negedge clk);
      check($sformatf("tbl%0d_req_valid", i), 32'(bus.mem_req_valid), 32'(tbl[i].ev));
      check($sformatf("tbl%0d_addr", i), bus.mem_req_addr, tbl[i].eaddr);
      check($sformatf("tbl%0d_out_valid", i), 32'(bus.out_valid), 32'(tbl[i].eov));
      check($sformatf("tbl%0d_out_pc", i), bus.out_pc, tbl[i].eopc);
      check($sformatf("tbl%0d_out_inst", i), bus.out_inst, tbl[i].einst);
      check($sformatf("tbl%0d_fetch_count", i), bus.fetch_count, tbl[i].ecnt);
      @(posedge clk); #1;
    end

    // stalled request, delayed response, then decode back-pressure
    do_reset();
    rst = 1'b0;
    idle_inputs();
    @(negedge clk); @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      bus.mem_req_ready = (i == 4);
      @(negedge clk);
      check("stall_req_valid", 32'(bus.mem_req_valid), 1);
      check("stall_addr", bus.mem_req_addr, RST_PC);
      @(posedge clk); #1;
    end
    bus.mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.mem_resp_valid = (i == 3);
      bus.mem_resp_data  = 32'h1234_5678;
      @(negedge clk);
      check("wait_out_valid", 32'(bus.out_valid), 0);
      check("wait_req_valid", 32'(bus.mem_req_valid), 0);
      @(posedge clk); #1;
    end
    bus.mem_resp_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.out_ready = (i == 5);
      @(negedge clk);
      check("hold_out_valid", 32'(bus.out_valid), 1);
      check("hold_out_pc", bus.out_pc, RST_PC);
      check("hold_out_inst", bus.out_inst, 32'h1234_5678);
      check("hold_req_valid", 32'(bus.mem_req_valid), 0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("after_hold_req_valid", 32'(bus.mem_req_valid), 1);
    check("after_hold_addr", bus.mem_req_addr, RST_PC + 32'd4);
    check("after_hold_count", bus.fetch_count, 1);
    check("after_hold_out_valid", 32'(bus.out_valid), 0);
    @(posedge clk); #1;

    // randomized run against the transaction model
    do_reset();
    rst = 1'b0;
    m_pc = RST_PC; m_cnt = 0; pend = 1'b0; timer = 0; n_out_hs = 0;
    for (int c = 0; c < 3000; c++) rnd_cycle(1'b0);
    check("rnd_progress", 32'(n_out_hs > 20), 1);

    // reach a fresh outstanding request, then reset mid-fetch with a stale response
    got_req = 1'b0;
    guard = 0;
    while (!got_req && guard < 50) begin
      a0 = 32'(pend);
      rnd_cycle(1'b1);
      got_req = pend && (a0 == 0);
      guard++;
    end
    check("reset_midfetch_setup", 32'(got_req), 1);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk); @(posedge clk); #1;
    rst = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'hDEAD_BEEF;
    bus.mem_req_ready  = 1'b0;
    @(negedge clk);
    check("stale_out_valid", 32'(bus.out_valid), 0);
    check("stale_fetch_count", bus.fetch_count, 0);
    @(posedge clk); #1;
    bus.mem_resp_valid = 1'b0;
    bus.out_ready      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_out_valid", 32'(bus.out_valid), 0);
      check("post_rst_req_valid", 32'(bus.mem_req_valid), 1);
      check("post_rst_addr", bus.mem_req_addr, RST_PC);
      check("post_rst_count", bus.fetch_count, 0);
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
